// File: rtl/mem_access_unit_pkg.sv
// mem_pkg: shared types and constants for the memory access unit.
//   ADDR_W      - data memory address width
//   BYTE_W      - data memory data width
//   WORD_W      - width of a 16-bit word access (two bytes)
//   mau_state_t - sequencer states
package mem_pkg;

  localparam int ADDR_W = 8;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 2 * BYTE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    FIN  = 2'd3
  } mau_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: bundles the datapath request/response signals and the
// byte-wide data memory bus of the memory access unit.
//   Request side : req, we, word, addr, wdata -> unit ; busy, done, rdata <- unit
//   Memory side  : Address, WriteData, MemRead, MemWrite <- unit ; ReadData -> unit
// Modports:
//   slave  - the memory access unit itself
//   master - the environment (controller plus data memory)
interface mem_access_unit_if;
  import mem_pkg::*;

  logic              req;
  logic              we;
  logic              word;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] rdata;

  logic [ADDR_W-1:0] Address;
  logic [BYTE_W-1:0] WriteData;
  logic              MemRead;
  logic              MemWrite;
  logic [BYTE_W-1:0] ReadData;

  modport slave (
    input  req, we, word, addr, wdata, ReadData,
    output busy, done, rdata, Address, WriteData, MemRead, MemWrite
  );

  modport master (
    output req, we, word, addr, wdata, ReadData,
    input  busy, done, rdata, Address, WriteData, MemRead, MemWrite
  );

endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences one byte or big-endian 16-bit word load/store
// at a time onto an 8-bit data memory (high byte at addr, low byte at addr+1).
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - mem_access_unit_if.slave: request handshake and memory bus
// Memory-side outputs decode only the state and latched-request registers,
// so nothing on the request inputs reaches the memory combinationally, and
// an asynchronous reset drops MemWrite immediately.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  mem_access_unit_if.slave          bus
);

  mau_state_t        r_state;
  mau_state_t        w_next;

  logic              r_we;
  logic              r_word;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [BYTE_W-1:0] r_hi;
  logic [WORD_W-1:0] r_rdata;

  logic [ADDR_W-1:0] w_addr_inc;
  logic [ADDR_W-1:0] w_address;
  logic [BYTE_W-1:0] w_write_data;
  logic              w_mem_read;
  logic              w_mem_write;

  // Natural truncation makes 255 wrap to 0 for the second byte.
  assign w_addr_inc = r_addr + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_address    = '0;
    w_write_data = '0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    case (r_state)
      IDLE: if (bus.req) w_next = ACC0;
      ACC0: begin
        w_address    = r_addr;
        w_write_data = r_word ? r_wdata[WORD_W-1:BYTE_W] : r_wdata[BYTE_W-1:0];
        w_mem_read   = ~r_we;
        w_mem_write  = r_we;
        w_next       = r_word ? ACC1 : FIN;
      end
      ACC1: begin
        w_address    = w_addr_inc;
        w_write_data = r_wdata[BYTE_W-1:0];
        w_mem_read   = ~r_we;
        w_mem_write  = r_we;
        w_next       = FIN;
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request latch and load assembly. A word load parks the high byte in r_hi
  // so rdata changes only once, when the whole load has completed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_word  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_hi    <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == IDLE && bus.req) begin
        r_we    <= bus.we;
        r_word  <= bus.word;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
      end
      if (r_state == ACC0 && !r_we) begin
        if (r_word) r_hi    <= bus.ReadData;
        else        r_rdata <= {{BYTE_W{1'b0}}, bus.ReadData};
      end
      if (r_state == ACC1 && !r_we) r_rdata <= {r_hi, bus.ReadData};
    end
  end

  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == FIN);
  assign bus.rdata     = r_rdata;
  assign bus.Address   = w_address;
  assign bus.WriteData = w_write_data;
  assign bus.MemRead   = w_mem_read;
  assign bus.MemWrite  = w_mem_write;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for mem_access_unit with a behavioural
// 256x8 data memory (combinational read, posedge write). Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  logic [BYTE_W-1:0] mem [256];

  mem_access_unit_if bus();

  mem_access_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.ReadData = mem[bus.Address];

  always @(posedge clk) begin
    if (bus.MemWrite) mem[bus.Address] <= bus.WriteData;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic we_i, input logic word_i,
                       input logic [ADDR_W-1:0] addr_i, input logic [WORD_W-1:0] wdata_i);
    bus.req   = 1'b1;
    bus.we    = we_i;
    bus.word  = word_i;
    bus.addr  = addr_i;
    bus.wdata = wdata_i;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[100] = 8'h83;
    mem[101] = 8'h14;
    mem[102] = 8'hA0;
    mem[103] = 8'h64;
    mem[51]  = 8'h77;

    bus.req = 1'b0; bus.we = 1'b0; bus.word = 1'b0; bus.addr = '0; bus.wdata = '0;
    rst = 1'b0;
    step(); step();
    check("rst_busy",      32'(bus.busy),      32'h0);
    check("rst_done",      32'(bus.done),      32'h0);
    check("rst_rdata",     32'(bus.rdata),     32'h0);
    check("rst_Address",   32'(bus.Address),   32'h0);
    check("rst_WriteData", 32'(bus.WriteData), 32'h0);
    check("rst_MemRead",   32'(bus.MemRead),   32'h0);
    check("rst_MemWrite",  32'(bus.MemWrite),  32'h0);
    rst = 1'b1;
    step();

    // Word load at 100
    issue(1'b0, 1'b1, 8'd100, 16'h0000);
    step();  // ACC0
    bus.req = 1'b0;
    check("wl_acc0_addr",  32'(bus.Address),  32'd100);
    check("wl_acc0_rd",    32'(bus.MemRead),  32'h1);
    check("wl_acc0_wr",    32'(bus.MemWrite), 32'h0);
    check("wl_acc0_busy",  32'(bus.busy),     32'h1);
    check("wl_acc0_done",  32'(bus.done),     32'h0);
    step();  // ACC1
    check("wl_acc1_addr",  32'(bus.Address),  32'd101);
    check("wl_acc1_rd",    32'(bus.MemRead),  32'h1);
    check("wl_acc1_done",  32'(bus.done),     32'h0);
    step();  // FIN
    check("wl_fin_done",   32'(bus.done),     32'h1);
    check("wl_fin_rd",     32'(bus.MemRead),  32'h0);
    check("wl_fin_rdata",  32'(bus.rdata),    32'h8314);
    step();  // IDLE
    check("wl_idle_done",  32'(bus.done),     32'h0);
    check("wl_idle_busy",  32'(bus.busy),     32'h0);

    // Byte load at 102
    issue(1'b0, 1'b0, 8'd102, 16'h0000);
    step();  // ACC0
    bus.req = 1'b0;
    check("bl_acc0_addr",  32'(bus.Address),  32'd102);
    check("bl_acc0_rd",    32'(bus.MemRead),  32'h1);
    step();  // FIN
    check("bl_fin_done",   32'(bus.done),     32'h1);
    check("bl_fin_rd",     32'(bus.MemRead),  32'h0);
    check("bl_fin_rdata",  32'(bus.rdata),    32'h00A0);
    step();

    // Word store 0xBEEF at 255, second byte wraps to 0
    issue(1'b1, 1'b1, 8'd255, 16'hBEEF);
    step();  // ACC0
    bus.req = 1'b0;
    check("ws_acc0_addr",  32'(bus.Address),   32'd255);
    check("ws_acc0_wd",    32'(bus.WriteData), 32'hBE);
    check("ws_acc0_wr",    32'(bus.MemWrite),  32'h1);
    check("ws_acc0_rd",    32'(bus.MemRead),   32'h0);
    step();  // ACC1
    check("ws_acc1_addr",  32'(bus.Address),   32'd0);
    check("ws_acc1_wd",    32'(bus.WriteData), 32'hEF);
    check("ws_acc1_wr",    32'(bus.MemWrite),  32'h1);
    step();  // FIN
    check("ws_fin_done",   32'(bus.done),      32'h1);
    check("ws_fin_wr",     32'(bus.MemWrite),  32'h0);
    check("ws_rdata_hold", 32'(bus.rdata),     32'h00A0);
    check("ws_mem255",     32'(mem[255]),      32'hBE);
    check("ws_mem0",       32'(mem[0]),        32'hEF);
    step();

    // Word load back from 255
    issue(1'b0, 1'b1, 8'd255, 16'h0000);
    step(); bus.req = 1'b0;
    step();
    step();  // FIN
    check("wl255_done",    32'(bus.done),      32'h1);
    check("wl255_rdata",   32'(bus.rdata),     32'hBEEF);
    step();

    // Request during ACC1 of a word load at 102 must be ignored
    issue(1'b0, 1'b1, 8'd102, 16'h0000);
    step();  // ACC0
    bus.req = 1'b0;
    step();  // ACC1
    issue(1'b1, 1'b0, 8'd10, 16'h0055);
    step();  // FIN
    bus.req = 1'b0;
    check("rb_fin_done",   32'(bus.done),      32'h1);
    check("rb_fin_rdata",  32'(bus.rdata),     32'hA064);
    step();  // IDLE
    check("rb_idle_busy",  32'(bus.busy),      32'h0);
    step();
    check("rb_mem10",      32'(mem[10]),       32'h00);

    // Reset pulled low in the middle of ACC1 of a word store
    issue(1'b1, 1'b1, 8'd50, 16'h1234);
    step();  // ACC0
    bus.req = 1'b0;
    check("rs_acc0_wr",    32'(bus.MemWrite),  32'h1);
    step();  // ACC1
    check("rs_acc1_wr",    32'(bus.MemWrite),  32'h1);
    #1 rst = 1'b0;
    #1;
    check("rs_wr_drop",    32'(bus.MemWrite),  32'h0);
    check("rs_busy",       32'(bus.busy),      32'h0);
    check("rs_rdata",      32'(bus.rdata),     32'h0);
    check("rs_Address",    32'(bus.Address),   32'h0);
    step();
    rst = 1'b1;
    check("rs_mem50",      32'(mem[50]),       32'h12);
    check("rs_mem51",      32'(mem[51]),       32'h77);
    step();

    // Back-to-back byte loads with req held high
    issue(1'b0, 1'b0, 8'd100, 16'h0000);
    step();  // ACC0 (first)
    check("bb1_acc0_addr", 32'(bus.Address),   32'd100);
    check("bb1_acc0_rd",   32'(bus.MemRead),   32'h1);
    step();  // FIN (first); req still high is ignored here
    bus.addr = 8'd101;
    check("bb1_fin_done",  32'(bus.done),      32'h1);
    check("bb1_fin_rd",    32'(bus.MemRead),   32'h0);
    check("bb1_fin_rdata", 32'(bus.rdata),     32'h0083);
    step();  // IDLE: second request accepted at the end of this cycle
    check("bb_idle_busy",  32'(bus.busy),      32'h0);
    check("bb_idle_rd",    32'(bus.MemRead),   32'h0);
    step();  // ACC0 (second)
    bus.req = 1'b0;
    check("bb2_acc0_addr", 32'(bus.Address),   32'd101);
    check("bb2_acc0_rd",   32'(bus.MemRead),   32'h1);
    step();  // FIN (second)
    check("bb2_fin_done",  32'(bus.done),      32'h1);
    check("bb2_fin_rd",    32'(bus.MemRead),   32'h0);
    check("bb2_fin_rdata", 32'(bus.rdata),     32'h0014);
    step();
    check("bb_end_busy",   32'(bus.busy),      32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
